// File: rtl/main_scu_clk_idle_ctrl.sv
// main_scu_clk_idle_ctrl: per-client idle-driven kernel clock gating with set/clr handshake to the misc stage
module main_scu_clk_idle_ctrl #(
  parameter int p_client_num = 32,
  parameter int p_cnt_width  = 16,
  parameter int p_evt_width  = 16
) (
  input  logic                    kernel_clk_i,
  input  logic                    reset_i,
  input  logic [p_client_num-1:0] auto_gate_en_i,
  input  logic [p_cnt_width-1:0]  idle_thresh_i,
  input  logic [p_client_num-1:0] busy_i,
  input  logic [p_client_num-1:0] wake_req_i,
  output logic [p_client_num-1:0] wake_ack_o,
  input  logic [p_client_num-1:0] kernel_clk_en_sta_i,
  output logic [p_client_num-1:0] kernel_clk_en_set_o,
  output logic [p_client_num-1:0] kernel_clk_en_clr_o,
  output logic [p_client_num-1:0] gated_o,
  output logic [p_evt_width-1:0]  gate_evt_cnt_o
);
  typedef enum logic [1:0] {RUN, WAIT_OFF, OFF, WAIT_ON} state_t;
  logic [p_client_num-1:0] w_clr_v;
  logic [p_evt_width:0]    w_sum;
  logic [p_evt_width-1:0]  r_evt;
  genvar g;
  for (g = 0; g < p_client_num; g++) begin : g_cl
    state_t r_st, w_st;
    logic [p_cnt_width-1:0] r_cnt, w_cnt;
    logic r_pend, w_pend, r_wdone, r_set, r_clr, r_ack, r_gated;
    logic w_set, w_clr, w_ack, w_hold, w_sta, w_wake;
    assign w_sta  = kernel_clk_en_sta_i[g];
    assign w_wake = wake_req_i[g];
    assign w_hold = busy_i[g] | w_wake | ~auto_gate_en_i[g];
    always_comb begin
      w_st   = r_st;
      w_cnt  = '0;
      w_pend = r_pend;
      w_set  = 1'b0;
      w_clr  = 1'b0;
      w_ack  = 1'b0;
      case (r_st)
        RUN: begin
          w_cnt = w_hold ? '0 : (&r_cnt ? r_cnt : r_cnt + p_cnt_width'(1));
          w_ack = w_wake & w_sta;
          if (!w_sta) w_st = OFF;
          else if (!w_hold && idle_thresh_i != '0 && r_cnt == idle_thresh_i) begin
            w_clr = 1'b1;
            w_st  = WAIT_OFF;
          end
        end
        WAIT_OFF: begin
          // activity arriving mid-gate is remembered so OFF can wake even if it has gone away
          w_pend = r_pend | busy_i[g] | w_wake;
          w_st   = w_sta ? WAIT_OFF : OFF;
        end
        OFF: begin
          if (w_sta) begin
            w_st   = RUN;
            w_pend = 1'b0;
          end else if (w_hold | r_pend) begin
            w_set  = 1'b1;
            w_st   = WAIT_ON;
            w_pend = 1'b0;
          end
        end
        WAIT_ON: begin
          w_st  = w_sta ? RUN : WAIT_ON;
          w_ack = w_sta & w_wake;
        end
      endcase
    end
    always_ff @(posedge kernel_clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_st    <= RUN;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_wdone <= 1'b0;
        r_set   <= 1'b0;
        r_clr   <= 1'b0;
        r_ack   <= 1'b0;
        r_gated <= 1'b0;
      end else begin
        r_st    <= w_st;
        r_cnt   <= w_cnt;
        r_pend  <= w_pend;
        r_wdone <= w_wake & (r_wdone | w_ack);
        r_set   <= w_set;
        r_clr   <= w_clr;
        r_ack   <= w_ack & ~r_wdone;
        r_gated <= w_st == OFF;
      end
    end
    assign w_clr_v[g]             = w_clr;
    assign kernel_clk_en_set_o[g] = r_set;
    assign kernel_clk_en_clr_o[g] = r_clr;
    assign wake_ack_o[g]          = r_ack;
    assign gated_o[g]             = r_gated;
  end
  always_comb begin
    w_sum = {1'b0, r_evt};
    for (int i = 0; i < p_client_num; i++) w_sum = w_sum + (p_evt_width+1)'(w_clr_v[i]);
  end
  always_ff @(posedge kernel_clk_i or posedge reset_i) begin
    if (reset_i) r_evt <= '0;
    else r_evt <= w_sum[p_evt_width] ? '1 : w_sum[p_evt_width-1:0];
  end
  assign gate_evt_cnt_o = r_evt;
endmodule

// File: tb/tb_main_scu_clk_idle_ctrl.sv
// tb_main_scu_clk_idle_ctrl: directed vector table plus corner-case sequences, with a one-cycle misc-stage status model
module tb_main_scu_clk_idle_ctrl;
  localparam int N = 4;
  logic clk = 1'b0, rst, misc_rst;
  logic [N-1:0] en, busy, wake, sta, set_o, clr_o, ack_o, gated_o;
  logic [15:0] thresh, evt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  main_scu_clk_idle_ctrl #(.p_client_num(N), .p_cnt_width(16), .p_evt_width(16)) dut (
    .kernel_clk_i(clk), .reset_i(rst), .auto_gate_en_i(en), .idle_thresh_i(thresh),
    .busy_i(busy), .wake_req_i(wake), .wake_ack_o(ack_o), .kernel_clk_en_sta_i(sta),
    .kernel_clk_en_set_o(set_o), .kernel_clk_en_clr_o(clr_o), .gated_o(gated_o),
    .gate_evt_cnt_o(evt));
  always @(posedge clk) sta <= misc_rst ? '1 : ((sta & ~clr_o) | set_o);
  typedef struct {
    logic [N-1:0] en, busy, wake, set, clr, ack, gated;
    logic [15:0]  evt;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic [N-1:0] e, b, w, s, c, a, gt, input logic [15:0] ev);
    vec_t v;
    v.en = e; v.busy = b; v.wake = w; v.set = s; v.clr = c; v.ack = a; v.gated = gt; v.evt = ev;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b1; misc_rst = 1'b1;
    en = '0; busy = '0; wake = '0; thresh = '0;
    step();
    step();
    chk({tag, " rst set"}, 32'(set_o), 0);
    chk({tag, " rst clr"}, 32'(clr_o), 0);
    chk({tag, " rst ack"}, 32'(ack_o), 0);
    chk({tag, " rst gated"}, 32'(gated_o), 0);
    chk({tag, " rst evt"}, 32'(evt), 0);
    rst = 1'b0; misc_rst = 1'b0;
  endtask
  initial begin
    int clrs, clr_c, set_c, ack_c, acks, coinc;
    rst = 1'b1; misc_rst = 1'b1; en = '0; busy = '0; wake = '0; thresh = '0;
    // client0/3 gate, client1 disabled, client2 busy; client0 wakes, client3 re-enabled-off
    for (int r = 1; r <= 4; r++) tv.push_back(mk(4'b1101, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 16'd0));
    tv.push_back(mk(4'b1101, 4'b0100, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 16'd2));
    tv.push_back(mk(4'b1101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd2));
    tv.push_back(mk(4'b1101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 16'd2));
    tv.push_back(mk(4'b1101, 4'b0100, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 16'd2));
    tv.push_back(mk(4'b1101, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 16'd2));
    tv.push_back(mk(4'b1101, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 16'd2));
    tv.push_back(mk(4'b1101, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 16'd2));
    tv.push_back(mk(4'b0101, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 16'd2));
    for (int r = 13; r <= 15; r++) tv.push_back(mk(4'b0101, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 16'd2));
    tv.push_back(mk(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 16'd3));
    tv.push_back(mk(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd3));
    tv.push_back(mk(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'd3));
    do_reset("table");
    thresh = 16'd4;
    foreach (tv[i]) begin
      en = tv[i].en; busy = tv[i].busy; wake = tv[i].wake;
      step();
      chk($sformatf("row%0d set", i + 1), 32'(set_o), 32'(tv[i].set));
      chk($sformatf("row%0d clr", i + 1), 32'(clr_o), 32'(tv[i].clr));
      chk($sformatf("row%0d ack", i + 1), 32'(ack_o), 32'(tv[i].ack));
      chk($sformatf("row%0d gated", i + 1), 32'(gated_o), 32'(tv[i].gated));
      chk($sformatf("row%0d evt", i + 1), 32'(evt), 32'(tv[i].evt));
    end
    // busy toggling every 3 cycles never lets the idle count reach 4
    do_reset("toggle");
    thresh = 16'd4; en = 4'b0001; clrs = 0;
    for (int c = 0; c < 60; c++) begin
      busy = ((c / 3) % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
      if (clr_o != '0) clrs++;
    end
    chk("toggle no clr", 32'(clrs), 0);
    chk("toggle not gated", 32'(gated_o), 0);
    // threshold 0 never gates; disabled clients never gate
    do_reset("never");
    en = '1; thresh = 16'd0; clrs = 0;
    repeat (500) begin step(); if (clr_o != '0) clrs++; end
    chk("thresh0 no clr", 32'(clrs), 0);
    en = '0; thresh = 16'd4; clrs = 0;
    repeat (500) begin step(); if (clr_o != '0) clrs++; end
    chk("en0 no clr", 32'(clrs), 0);
    chk("never evt", 32'(evt), 0);
    // wake raised during the clr pulse: served from OFF after WAIT_OFF
    do_reset("wake_at_clr");
    en = 4'b0001; thresh = 16'd4;
    clr_c = -1; set_c = -1; ack_c = -1; acks = 0; coinc = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (clr_o[0] && clr_c < 0) clr_c = c;
      if (set_o[0] && set_c < 0) set_c = c;
      if (|(set_o & clr_o)) coinc++;
      if (ack_o[0]) begin acks++; if (ack_c < 0) ack_c = c; wake = 4'b0000; end
      if (c == 5) wake = 4'b0001;
    end
    chk("wac clr cycle", 32'(clr_c), 5);
    chk("wac set cycle", 32'(set_c), 8);
    chk("wac ack cycle", 32'(ack_c), 10);
    chk("wac ack count", 32'(acks), 1);
    chk("wac set&clr", 32'(coinc), 0);
    // reset while waiting for the clock to come back on
    do_reset("rst_wait_on");
    en = 4'b0001; thresh = 16'd4;
    repeat (7) step();
    chk("rwo gated", 32'(gated_o), 1);
    chk("rwo evt", 32'(evt), 1);
    wake = 4'b0001;
    step();
    chk("rwo set", 32'(set_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("rwo async set", 32'(set_o), 0);
    chk("rwo async gated", 32'(gated_o), 0);
    chk("rwo async evt", 32'(evt), 0);
    step();
    step();
    rst = 1'b0;
    acks = 0;
    repeat (20) begin
      step();
      if (ack_o[0]) begin acks++; wake = 4'b0000; end
    end
    chk("rwo ack once", 32'(acks), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
